// File: rtl/mem_request_responder.sv
// Serialises data and instruction requests onto a single-ported RAM and returns one-cycle hit pulses.
// Latency: the hit arrives one cycle after ram_ready; minimum two cycles from the request seen in IDLE.
// Backpressure: requesters hold their level strobes until the hit; ram_ready stalls the access indefinitely.
// Optional watchdog on ram_ready is enabled by defining MEM_RESPONDER_TIMEOUT_EN.
module mem_request_responder #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              imemren,
  input  logic [ADDR_W-1:0] imemaddr,
  output logic [DATA_W-1:0] imemload,
  output logic              ihit,
  input  logic              dmemren,
  input  logic              dmemwen,
  input  logic [ADDR_W-1:0] dmemaddr,
  input  logic [DATA_W-1:0] dmemstore,
  output logic [DATA_W-1:0] dmemload,
  output logic              dhit,
  output logic              ram_ren,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_store,
  input  logic [DATA_W-1:0] ram_load,
  input  logic              ram_ready,
  output logic              busy,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DACC = 3'd1,
    IACC = 3'd2,
    DRSP = 3'd3,
    IRSP = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic              ram_ren_q, ram_ren_d;
  logic              ram_wen_q, ram_wen_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_store_q, ram_store_d;
  logic [DATA_W-1:0] imemload_q, imemload_d;
  logic [DATA_W-1:0] dmemload_q, dmemload_d;
  logic              ihit_q, ihit_d;
  logic              dhit_q, dhit_d;
  logic              timed_out;

`ifdef MEM_RESPONDER_TIMEOUT_EN
  localparam int unsigned     CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [DATA_W-1:0] BAD_LOAD = DATA_W'(32'hBAD1BAD1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // The access gives up once TIMEOUT strobe cycles have passed without ram_ready.
  assign timed_out = (cnt_q == CNT_LAST) && !ram_ready;
`else
  assign timed_out = 1'b0;
`endif

  // Next-state and registered-output logic; strobes and address are latched on entry and held.
  always_comb begin
    state_d     = state_q;
    ram_ren_d   = ram_ren_q;
    ram_wen_d   = ram_wen_q;
    ram_addr_d  = ram_addr_q;
    ram_store_d = ram_store_q;
    imemload_d  = imemload_q;
    dmemload_d  = dmemload_q;
    ihit_d      = 1'b0;
    dhit_d      = 1'b0;
`ifdef MEM_RESPONDER_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (dmemwen || dmemren) begin
          state_d     = DACC;
          ram_wen_d   = dmemwen;
          ram_ren_d   = dmemren & ~dmemwen;
          ram_addr_d  = dmemaddr;
          ram_store_d = dmemstore;
`ifdef MEM_RESPONDER_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end else if (imemren) begin
          state_d    = IACC;
          ram_ren_d  = 1'b1;
          ram_wen_d  = 1'b0;
          ram_addr_d = imemaddr;
`ifdef MEM_RESPONDER_TIMEOUT_EN
          cnt_d      = '0;
`endif
        end
      end
      DACC: begin
        if (ram_ready) begin
          state_d   = DRSP;
          ram_ren_d = 1'b0;
          ram_wen_d = 1'b0;
          dhit_d    = 1'b1;
          // A write completes without disturbing the last load value.
          if (ram_ren_q) dmemload_d = ram_load;
        end else if (timed_out) begin
`ifdef MEM_RESPONDER_TIMEOUT_EN
          state_d   = DRSP;
          ram_ren_d = 1'b0;
          ram_wen_d = 1'b0;
          dhit_d    = 1'b1;
          err_d     = 1'b1;
          if (ram_ren_q) dmemload_d = BAD_LOAD;
`endif
        end else begin
`ifdef MEM_RESPONDER_TIMEOUT_EN
          cnt_d = cnt_q + CNT_W'(1);
`endif
        end
      end
      IACC: begin
        if (ram_ready) begin
          state_d    = IRSP;
          ram_ren_d  = 1'b0;
          ihit_d     = 1'b1;
          imemload_d = ram_load;
        end else if (timed_out) begin
`ifdef MEM_RESPONDER_TIMEOUT_EN
          state_d    = IRSP;
          ram_ren_d  = 1'b0;
          ihit_d     = 1'b1;
          err_d      = 1'b1;
          imemload_d = BAD_LOAD;
`endif
        end else begin
`ifdef MEM_RESPONDER_TIMEOUT_EN
          cnt_d = cnt_q + CNT_W'(1);
`endif
        end
      end
      // The response cycle gives the requester one edge to drop its strobe before IDLE looks again.
      DRSP:    state_d = IDLE;
      IRSP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset; reset mid-access drops strobes without a hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ram_ren_q   <= 1'b0;
      ram_wen_q   <= 1'b0;
      ram_addr_q  <= '0;
      ram_store_q <= '0;
      imemload_q  <= '0;
      dmemload_q  <= '0;
      ihit_q      <= 1'b0;
      dhit_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ram_ren_q   <= ram_ren_d;
      ram_wen_q   <= ram_wen_d;
      ram_addr_q  <= ram_addr_d;
      ram_store_q <= ram_store_d;
      imemload_q  <= imemload_d;
      dmemload_q  <= dmemload_d;
      ihit_q      <= ihit_d;
      dhit_q      <= dhit_d;
    end
  end

`ifdef MEM_RESPONDER_TIMEOUT_EN
  // Watchdog counter and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign imemload  = imemload_q;
  assign dmemload  = dmemload_q;
  assign ihit      = ihit_q;
  assign dhit      = dhit_q;
  assign ram_ren   = ram_ren_q;
  assign ram_wen   = ram_wen_q;
  assign ram_addr  = ram_addr_q;
  assign ram_store = ram_store_q;
  assign busy      = (state_q != IDLE);

endmodule
